// File: rtl/addsub_share_ctrl.sv
// Round-robin controller sharing one external 3-bit add/sub datapath between NREQ requesters.
// Optional per-requester grant counters are enabled by defining ADDSUB_SHARE_CTRL_STATS_EN.
module addsub_share_ctrl #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [3*NREQ-1:0] req_a_i,
    input  logic [3*NREQ-1:0] req_b_i,
    input  logic [NREQ-1:0]   req_op_i,
    output logic [NREQ-1:0]   rsp_valid_o,
    input  logic [NREQ-1:0]   rsp_ready_i,
    output logic [3:0]        rsp_result_o,
    output logic              dp_sel_o,
    output logic [2:0]        dp_a_o,
    output logic [2:0]        dp_b_o,
    input  logic [3:0]        dp_result_i,
`ifdef ADDSUB_SHARE_CTRL_STATS_EN
    input  logic              stats_clr_i,
    output logic [8*NREQ-1:0] grant_cnt_o,
`endif
    output logic              busy_o
);

    localparam int unsigned IdxW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   gnt_q, gnt_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              dp_sel_q, dp_sel_d;
    logic [2:0]        dp_a_q, dp_a_d;
    logic [2:0]        dp_b_q, dp_b_d;
    logic [3:0]        rsp_result_q, rsp_result_d;

    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW-1:0]   cand;

    // First valid requester starting from the round-robin pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % NREQ);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        dp_sel_d     = dp_sel_q;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        rsp_result_d = rsp_result_q;
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    req_ready_o[win_idx] = 1'b1;
                    dp_a_d   = req_a_i[3*win_idx +: 3];
                    dp_b_d   = req_b_i[3*win_idx +: 3];
                    dp_sel_d = req_op_i[win_idx];
                    cnt_d    = 4'(SETTLE - 1);
                    gnt_d    = win_idx;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = dp_result_i;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                rsp_valid_o[gnt_q] = 1'b1;
                if (rsp_ready_i[gnt_q]) begin
                    ptr_d   = (gnt_q == IdxW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            gnt_q        <= '0;
            cnt_q        <= '0;
            dp_sel_q     <= 1'b0;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            dp_sel_q     <= dp_sel_d;
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign dp_sel_o     = dp_sel_q;
    assign dp_a_o       = dp_a_q;
    assign dp_b_o       = dp_b_q;
    assign rsp_result_o = rsp_result_q;
    assign busy_o       = (state_q != StIdle);

`ifdef ADDSUB_SHARE_CTRL_STATS_EN
    logic [NREQ-1:0][7:0] gcnt_q, gcnt_d;

    // Clear takes priority over a coincident accept; counters saturate at 255.
    always_comb begin
        gcnt_d = gcnt_q;
        if (stats_clr_i) begin
            gcnt_d = '0;
        end else if (state_q == StIdle && win_found && gcnt_q[win_idx] != 8'hFF) begin
            gcnt_d[win_idx] = gcnt_q[win_idx] + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign grant_cnt_o = gcnt_q;
`endif

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Scoreboard bench for addsub_share_ctrl: random and directed traffic against an arithmetic model.
module tb_addsub_share_ctrl;
    localparam int NREQ   = 4;
    localparam int SETTLE = 2;

    logic              clk, rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, req_op, rsp_valid, rsp_ready;
    logic [3*NREQ-1:0] req_a, req_b;
    logic [3:0]        rsp_result, dp_result;
    logic              dp_sel, busy;
    logic [2:0]        dp_a, dp_b;
`ifdef ADDSUB_SHARE_CTRL_STATS_EN
    logic              stats_clr;
    logic [8*NREQ-1:0] grant_cnt;
`endif

    addsub_share_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_op_i    (req_op),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_result_o(rsp_result),
        .dp_sel_o    (dp_sel),
        .dp_a_o      (dp_a),
        .dp_b_o      (dp_b),
        .dp_result_i (dp_result),
`ifdef ADDSUB_SHARE_CTRL_STATS_EN
        .stats_clr_i (stats_clr),
        .grant_cnt_o (grant_cnt),
`endif
        .busy_o      (busy)
    );

    // External shared datapath.
    always_comb begin
        if (dp_sel) dp_result = {1'b0, dp_a} + {1'b0, dp_b};
        else        dp_result = {dp_a < dp_b, 3'(dp_a - dp_b)};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [3:0] res;
        logic [2:0] a;
        logic [2:0] b;
        logic       op;
        int         acc;
    } txn_t;

    txn_t       sb[$];
    int         gseq[$];
    bit         rec_gseq = 0;
    bit         front_seen = 0;
    int         total = 0, bad = 0;
    int         model_ptr = 0;
    int         rel_cyc = -1;
    int         acc_cnt[NREQ];
    logic [3:0] last_res = '0;

    function automatic logic [3:0] ref_result(int a, int b, bit op);
        int s;
        if (op) begin
            s = a + b;
            return {s >= 8, 3'(s % 8)};
        end
        s = a - b;
        return {a < b, 3'((s + 8) % 8)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Accept monitor: expected grant from round-robin rule, pushes expected response.
    initial begin
        foreach (acc_cnt[i]) acc_cnt[i] = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                logic [NREQ-1:0] exp_rdy;
                int widx;
                exp_rdy = '0;
                widx = -1;
                if (sb.size() == 0 && cyc > rel_cyc) begin
                    for (int k = 0; k < NREQ; k++) begin
                        int i;
                        i = (model_ptr + k) % NREQ;
                        if (widx < 0 && req_valid[i]) widx = i;
                    end
                end
                if (widx >= 0) exp_rdy[widx] = 1'b1;
                check("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (widx >= 0) begin
                    txn_t t;
                    t.idx = widx;
                    t.a   = req_a[3*widx +: 3];
                    t.b   = req_b[3*widx +: 3];
                    t.op  = req_op[widx];
                    t.res = ref_result(int'(t.a), int'(t.b), t.op);
                    t.acc = cyc;
                    sb.push_back(t);
                    acc_cnt[widx]++;
                    if (rec_gseq) gseq.push_back(widx);
                end
            end
        end
    end

    // Response monitor: pops and compares whenever a response is presented.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    txn_t t;
                    logic [NREQ-1:0] oh;
                    t = sb[0];
                    oh = '0;
                    oh[t.idx] = 1'b1;
                    check("rsp_valid", 32'(rsp_valid), 32'(oh));
                    check("rsp_result", 32'(rsp_result), 32'(t.res));
                    check("req_ready_in_resp", 32'(req_ready), 32'd0);
                    check("busy_in_resp", 32'(busy), 32'd1);
                    check("dp_hold", {23'd0, dp_sel, dp_a, dp_b}, {23'd0, t.op, t.a, t.b});
                    if (!front_seen) begin
                        front_seen = 1;
                        check("latency", cyc, t.acc + 1 + SETTLE);
                    end
                    if (rsp_ready[t.idx]) begin
                        last_res = t.res;
                        void'(sb.pop_front());
                        front_seen = 0;
                        model_ptr = (t.idx + 1) % NREQ;
                        rel_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic drive_req(int i, int a, int b, bit op);
        req_valid[i]     = 1'b1;
        req_a[3*i +: 3]  = 3'(a);
        req_b[3*i +: 3]  = 3'(b);
        req_op[i]        = op;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0 && !busy) done = 1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        check({tag, "_dp"}, {25'd0, dp_sel, dp_a, dp_b}, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
`ifdef ADDSUB_SHARE_CTRL_STATS_EN
        stats_clr = 1'b0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed add, then two subtracts.
        @(negedge clk);
        rsp_ready = '1;
        drive_req(1, 5, 6, 1);
        @(negedge clk);
        req_valid = '0;
        #3 check("dp_sel_add", 32'(dp_sel), 32'd1);
        check("busy_settle", 32'(busy), 32'd1);
        drain();
        check("add_5_6", 32'(last_res), 32'b1011);

        @(negedge clk);
        drive_req(0, 2, 5, 0);
        @(negedge clk);
        req_valid = '0;
        #3 check("dp_sel_sub", 32'(dp_sel), 32'd0);
        drain();
        check("sub_2_5", 32'(last_res), 32'b1101);

        @(negedge clk);
        drive_req(0, 6, 3, 0);
        @(negedge clk);
        req_valid = '0;
        drain();
        check("sub_6_3", 32'(last_res), 32'b0011);

        // All requesters continuously valid: fair rotation.
        gseq.delete();
        rec_gseq = 1;
        for (int n = 0; n < 44; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                drive_req(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        req_valid = '0;
        rec_gseq = 0;
        drain();
        check("rr_count", 32'(gseq.size() >= 8), 32'd1);
        for (int j = 0; j + NREQ <= gseq.size(); j++) begin
            logic [NREQ-1:0] seen;
            seen = '0;
            for (int k = 0; k < NREQ; k++) seen[gseq[j+k]] = 1'b1;
            check("rr_window", 32'(seen), 32'hF);
        end

        // Back-pressure on requester 2 for 10 cycles.
        @(negedge clk);
        rsp_ready = 4'b1011;
        drive_req(2, 7, 4, 1);
        @(negedge clk);
        req_valid = '1;
        for (int n = 0; n < 20 && !rsp_valid[2]; n++) @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #3;
            check("hold_rsp_valid", 32'(rsp_valid), 32'b0100);
            check("hold_rsp_result", 32'(rsp_result), 32'b1011);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = '1;
        drain();

        // Randomized traffic with random response back-pressure.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                drive_req(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)));
                req_valid[i] = ($urandom_range(0, 9) < 6);
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = '1;
        drain();

        // Reset in the middle of SETTLE discards the operation.
        @(negedge clk);
        drive_req(2, 7, 1, 0);
        @(negedge clk);
        req_valid = '0;
        #3;
        rst_n = 1'b0;
        sb.delete();
        front_seen = 0;
        model_ptr = 0;
        rel_cyc = cyc;
        #1 check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            #3 check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) drive_req(i, i + 1, i, 1);
        #3 check("first_grant_after_reset", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        drain();

`ifdef ADDSUB_SHARE_CTRL_STATS_EN
        begin
            int start, n;
            @(negedge clk);
            stats_clr = 1'b1;
            @(negedge clk);
            stats_clr = 1'b0;
            start = acc_cnt[3];
            n = 0;
            drive_req(3, 1, 1, 1);
            while (acc_cnt[3] - start < 300 && n < 5000) begin
                @(negedge clk);
                n++;
                if (acc_cnt[3] - start >= 299) req_valid = '0;
            end
            req_valid = '0;
            drain();
            check("stats_grants_issued", acc_cnt[3] - start, 300);
            check("stats_sat", 32'(grant_cnt[31:24]), 32'd255);
            check("stats_other", 32'(grant_cnt[7:0]), 32'd0);
            @(negedge clk);
            stats_clr = 1'b1;
            @(negedge clk);
            stats_clr = 1'b0;
            #1 check("stats_clr", 32'(grant_cnt), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
